// File: rtl/rx_packet_deframer.sv
// Receive-side deframer: assembles ring-link bytes into whole packets,
// checks header parity / DATA_C checksum, votes DATA_3 copies, and holds
// the result for the control FSM until it is consumed.
module rx_packet_deframer #(
  parameter int PAYLOAD_BYTES  = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                       Clk_R,
  input  logic                       Rst_n,
  input  logic [7:0]                 rx_byte,
  input  logic                       rx_byte_valid,
  input  logic                       rc_ready,
  output logic                       rx_has_data,
  output logic [2:0]                 pkt_type,
  output logic [3:0]                 address,
  output logic                       bad_decode,
  output logic [8*PAYLOAD_BYTES-1:0] rx_payload,
  output logic                       rx_overrun,
  output logic                       rx_timeout
);

  localparam int PW     = 8 * PAYLOAD_BYTES;
  localparam int LANE_W = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;
  localparam int CNT_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(PAYLOAD_BYTES - 1);
  localparam logic [CNT_W-1:0]  TMO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] T_TOKEN = 3'b111;
  localparam logic [2:0] T_ACK   = 3'b000;
  localparam logic [2:0] T_NACK  = 3'b011;
  localparam logic [2:0] T_DATAC = 3'b010;
  localparam logic [2:0] T_DATA3 = 3'b001;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_PAYLOAD  = 2'd1,
    S_CHECKSUM = 2'd2,
    S_RESYNC   = 2'd3
  } state_t;

  // Header carries even parity: any odd number of ones marks it corrupt.
  function automatic logic parity_bad(input logic [7:0] b);
    return ^b;
  endfunction

  // Bitwise 2-of-3 majority across the three DATA_3 copies.
  function automatic logic [7:0] vote3(input logic [7:0] a, input logic [7:0] b,
                                       input logic [7:0] c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic logic [7:0] lane_get(input logic [PW-1:0] v, input logic [LANE_W-1:0] l);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 0; i < PAYLOAD_BYTES; i++) begin
      if (l == LANE_W'(i)) r = v[i*8 +: 8];
    end
    return r;
  endfunction

  function automatic logic [PW-1:0] lane_put(input logic [PW-1:0] v, input logic [LANE_W-1:0] l,
                                             input logic [7:0] b);
    logic [PW-1:0] r;
    r = v;
    for (int i = 0; i < PAYLOAD_BYTES; i++) begin
      if (l == LANE_W'(i)) r[i*8 +: 8] = b;
    end
    return r;
  endfunction

  state_t            state_r, state_nxt_s;
  logic [CNT_W-1:0]  cnt_r, cnt_nxt_s, cnt_inc_s;
  logic [LANE_W-1:0] lane_r, lane_nxt_s;
  logic [1:0]        copy_r, copy_nxt_s;
  logic [2:0]        hdr_type_r, hdr_type_nxt_s;
  logic [3:0]        hdr_addr_r, hdr_addr_nxt_s;
  logic [7:0]        csum_r, csum_nxt_s;
  logic [PW-1:0]     copy1_r, copy1_nxt_s;
  logic [PW-1:0]     copy2_r, copy2_nxt_s;
  logic [PW-1:0]     asm_r, asm_nxt_s;
  logic [7:0]        vote_s;
  logic [2:0]        in_type_s;
  logic              has_nxt_s, bad_nxt_s, ovr_nxt_s, tmo_nxt_s;
  logic [2:0]        type_nxt_s;
  logic [3:0]        addr_nxt_s;
  logic [PW-1:0]     pay_nxt_s;

  // Next-state, datapath and output computation for the deframer FSM.
  always_comb begin
    state_nxt_s    = state_r;
    cnt_nxt_s      = cnt_r;
    lane_nxt_s     = lane_r;
    copy_nxt_s     = copy_r;
    hdr_type_nxt_s = hdr_type_r;
    hdr_addr_nxt_s = hdr_addr_r;
    csum_nxt_s     = csum_r;
    copy1_nxt_s    = copy1_r;
    copy2_nxt_s    = copy2_r;
    asm_nxt_s      = asm_r;
    has_nxt_s      = rx_has_data & ~rc_ready;
    type_nxt_s     = pkt_type;
    addr_nxt_s     = address;
    bad_nxt_s      = bad_decode;
    pay_nxt_s      = rx_payload;
    ovr_nxt_s      = 1'b0;
    tmo_nxt_s      = 1'b0;
    in_type_s      = rx_byte[7:5];
    vote_s         = vote3(lane_get(copy1_r, lane_r), lane_get(copy2_r, lane_r), rx_byte);
    cnt_inc_s      = (cnt_r == TMO_LAST) ? cnt_r : cnt_r + CNT_W'(1);

    case (state_r)
      S_IDLE: begin
        if (!rx_byte_valid) begin
          state_nxt_s = S_IDLE;
        end else if (rx_has_data && !rc_ready) begin
          // Control still owns the held packet: drop the newcomer and resync.
          ovr_nxt_s   = 1'b1;
          cnt_nxt_s   = {CNT_W{1'b0}};
          state_nxt_s = S_RESYNC;
        end else if (parity_bad(rx_byte) ||
                     !(in_type_s == T_TOKEN || in_type_s == T_ACK || in_type_s == T_NACK ||
                       in_type_s == T_DATAC || in_type_s == T_DATA3)) begin
          has_nxt_s   = 1'b1;
          type_nxt_s  = in_type_s;
          addr_nxt_s  = rx_byte[4:1];
          bad_nxt_s   = 1'b1;
          pay_nxt_s   = {PW{1'b0}};
          cnt_nxt_s   = {CNT_W{1'b0}};
          state_nxt_s = S_RESYNC;
        end else if (in_type_s == T_TOKEN || in_type_s == T_ACK || in_type_s == T_NACK) begin
          has_nxt_s   = 1'b1;
          type_nxt_s  = in_type_s;
          addr_nxt_s  = rx_byte[4:1];
          bad_nxt_s   = 1'b0;
          pay_nxt_s   = {PW{1'b0}};
          state_nxt_s = S_IDLE;
        end else begin
          hdr_type_nxt_s = in_type_s;
          hdr_addr_nxt_s = rx_byte[4:1];
          csum_nxt_s     = rx_byte;
          lane_nxt_s     = {LANE_W{1'b0}};
          copy_nxt_s     = 2'd0;
          cnt_nxt_s      = {CNT_W{1'b0}};
          asm_nxt_s      = {PW{1'b0}};
          state_nxt_s    = S_PAYLOAD;
        end
      end

      S_PAYLOAD: begin
        if (rx_byte_valid) begin
          cnt_nxt_s = {CNT_W{1'b0}};
          if (hdr_type_r == T_DATAC) begin
            asm_nxt_s  = lane_put(asm_r, lane_r, rx_byte);
            csum_nxt_s = csum_r ^ rx_byte;
            if (lane_r == LAST_LANE) begin
              state_nxt_s = S_CHECKSUM;
            end else begin
              lane_nxt_s = lane_r + LANE_W'(1);
            end
          end else begin
            case (copy_r)
              2'd0:    copy1_nxt_s = lane_put(copy1_r, lane_r, rx_byte);
              2'd1:    copy2_nxt_s = lane_put(copy2_r, lane_r, rx_byte);
              default: asm_nxt_s   = lane_put(asm_r, lane_r, vote_s);
            endcase
            if (lane_r != LAST_LANE) begin
              lane_nxt_s = lane_r + LANE_W'(1);
            end else if (copy_r != 2'd2) begin
              lane_nxt_s = {LANE_W{1'b0}};
              copy_nxt_s = copy_r + 2'd1;
            end else begin
              // Header already passed parity and the vote repairs any single bad copy.
              has_nxt_s   = 1'b1;
              type_nxt_s  = hdr_type_r;
              addr_nxt_s  = hdr_addr_r;
              bad_nxt_s   = 1'b0;
              pay_nxt_s   = lane_put(asm_r, lane_r, vote_s);
              state_nxt_s = S_IDLE;
            end
          end
        end else if (cnt_r == TMO_LAST) begin
          tmo_nxt_s   = 1'b1;
          state_nxt_s = S_IDLE;
        end else begin
          cnt_nxt_s = cnt_inc_s;
        end
      end

      S_CHECKSUM: begin
        if (rx_byte_valid) begin
          has_nxt_s   = 1'b1;
          type_nxt_s  = hdr_type_r;
          addr_nxt_s  = hdr_addr_r;
          bad_nxt_s   = (rx_byte != csum_r);
          pay_nxt_s   = asm_r;
          state_nxt_s = S_IDLE;
        end else if (cnt_r == TMO_LAST) begin
          tmo_nxt_s   = 1'b1;
          state_nxt_s = S_IDLE;
        end else begin
          cnt_nxt_s = cnt_inc_s;
        end
      end

      S_RESYNC: begin
        if (rx_byte_valid) begin
          cnt_nxt_s = {CNT_W{1'b0}};
        end else if (cnt_r == TMO_LAST) begin
          state_nxt_s = S_IDLE;
        end else begin
          cnt_nxt_s = cnt_inc_s;
        end
      end

      default: begin
        state_nxt_s = S_IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs with synchronous active-low reset.
  always_ff @(posedge Clk_R) begin
    if (!Rst_n) begin
      state_r     <= S_IDLE;
      cnt_r       <= {CNT_W{1'b0}};
      lane_r      <= {LANE_W{1'b0}};
      copy_r      <= 2'd0;
      hdr_type_r  <= 3'd0;
      hdr_addr_r  <= 4'd0;
      csum_r      <= 8'd0;
      copy1_r     <= {PW{1'b0}};
      copy2_r     <= {PW{1'b0}};
      asm_r       <= {PW{1'b0}};
      rx_has_data <= 1'b0;
      pkt_type    <= 3'd0;
      address     <= 4'd0;
      bad_decode  <= 1'b0;
      rx_payload  <= {PW{1'b0}};
      rx_overrun  <= 1'b0;
      rx_timeout  <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      cnt_r       <= cnt_nxt_s;
      lane_r      <= lane_nxt_s;
      copy_r      <= copy_nxt_s;
      hdr_type_r  <= hdr_type_nxt_s;
      hdr_addr_r  <= hdr_addr_nxt_s;
      csum_r      <= csum_nxt_s;
      copy1_r     <= copy1_nxt_s;
      copy2_r     <= copy2_nxt_s;
      asm_r       <= asm_nxt_s;
      rx_has_data <= has_nxt_s;
      pkt_type    <= type_nxt_s;
      address     <= addr_nxt_s;
      bad_decode  <= bad_nxt_s;
      rx_payload  <= pay_nxt_s;
      rx_overrun  <= ovr_nxt_s;
      rx_timeout  <= tmo_nxt_s;
    end
  end

endmodule

// File: tb/tb_rx_packet_deframer.sv
// Scoreboard bench for rx_packet_deframer: directed byte streams push the
// expected packets/pulses; a negedge monitor pops and compares them.
module tb_rx_packet_deframer;

  logic        Clk_R;
  logic        Rst_n;
  logic [7:0]  rx_byte;
  logic        rx_byte_valid;
  logic        rc_ready;
  logic        rx_has_data;
  logic [2:0]  pkt_type;
  logic [3:0]  address;
  logic        bad_decode;
  logic [31:0] rx_payload;
  logic        rx_overrun;
  logic        rx_timeout;

  rx_packet_deframer #(.PAYLOAD_BYTES(4), .TIMEOUT_CYCLES(64)) dut (
    .Clk_R(Clk_R), .Rst_n(Rst_n), .rx_byte(rx_byte), .rx_byte_valid(rx_byte_valid),
    .rc_ready(rc_ready), .rx_has_data(rx_has_data), .pkt_type(pkt_type), .address(address),
    .bad_decode(bad_decode), .rx_payload(rx_payload), .rx_overrun(rx_overrun),
    .rx_timeout(rx_timeout)
  );

  localparam logic [1:0] EV_PKT = 2'd0;
  localparam logic [1:0] EV_OVR = 2'd1;
  localparam logic [1:0] EV_TMO = 2'd2;

  typedef struct {
    logic [1:0]  kind;
    logic [2:0]  typ;
    logic [3:0]  addr;
    logic        bad;
    logic [31:0] pay;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  int   errors = 0;
  int   checks = 0;
  logic has_prev = 1'b0;
  logic rdy_prev = 1'b0;

  initial Clk_R = 1'b0;
  always #5 Clk_R = ~Clk_R;

  task automatic push(input logic [1:0] k, input logic [2:0] t, input logic [3:0] a,
                      input logic b, input logic [31:0] p);
    exp_t e;
    e.kind = k; e.typ = t; e.addr = a; e.bad = b; e.pay = p;
    q.push_back(e);
  endtask

  task automatic drive(input logic [7:0] b, input logic rdy);
    rx_byte = b; rx_byte_valid = 1'b1; rc_ready = rdy;
    @(posedge Clk_R); #1;
    rx_byte_valid = 1'b0; rc_ready = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge Clk_R); #1; end
  endtask

  task automatic consume();
    rc_ready = 1'b1;
    @(posedge Clk_R); #1;
    rc_ready = 1'b0;
  endtask

  task automatic check1(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic pop_event(input logic [1:0] kind);
    exp_t e;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event got kind=%0d want none", kind);
    end else begin
      e = q.pop_front();
      if (e.kind != kind) begin
        errors++;
        $display("FAIL event_kind got=%0d want=%0d", kind, e.kind);
      end else if (kind == EV_PKT &&
                   {pkt_type, address, bad_decode, rx_payload} !== {e.typ, e.addr, e.bad, e.pay}) begin
        errors++;
        $display("FAIL packet got type=%b addr=%h bad=%b pay=%h want type=%b addr=%h bad=%b pay=%h",
                 pkt_type, address, bad_decode, rx_payload, e.typ, e.addr, e.bad, e.pay);
      end
      if (kind == EV_PKT) cur = e;
    end
  endtask

  // Monitor: pops the scoreboard on every pulse and every newly presented packet.
  always @(negedge Clk_R) begin
    if (!Rst_n) begin
      has_prev <= 1'b0;
      rdy_prev <= 1'b0;
    end else begin
      if (rx_overrun) pop_event(EV_OVR);
      if (rx_timeout) pop_event(EV_TMO);
      if (rx_has_data && (!has_prev || rdy_prev)) begin
        pop_event(EV_PKT);
      end else if (rx_has_data) begin
        checks++;
        if ({pkt_type, address, bad_decode, rx_payload} !== {cur.typ, cur.addr, cur.bad, cur.pay}) begin
          errors++;
          $display("FAIL hold got type=%b addr=%h bad=%b pay=%h want type=%b addr=%h bad=%b pay=%h",
                   pkt_type, address, bad_decode, rx_payload, cur.typ, cur.addr, cur.bad, cur.pay);
        end
      end
      has_prev <= rx_has_data;
      rdy_prev <= rc_ready;
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_all_zero(input string name);
    check1({name, "_has"}, {31'd0, rx_has_data}, 32'd0);
    check1({name, "_type"}, {29'd0, pkt_type}, 32'd0);
    check1({name, "_addr"}, {28'd0, address}, 32'd0);
    check1({name, "_bad"}, {31'd0, bad_decode}, 32'd0);
    check1({name, "_pay"}, rx_payload, 32'd0);
    check1({name, "_pulses"}, {30'd0, rx_overrun, rx_timeout}, 32'd0);
  endtask

  // Directed stimulus with hand-computed expectations.
  initial begin
    Rst_n = 1'b0; rx_byte = 8'h00; rx_byte_valid = 1'b0; rc_ready = 1'b0;
    repeat (3) @(posedge Clk_R);
    #1;
    check_all_zero("reset");
    Rst_n = 1'b1;

    // TOKEN to address 1, then consume.
    push(EV_PKT, 3'b111, 4'h1, 1'b0, 32'h0);
    drive(8'hE2, 1'b0);
    idle(2);
    consume();
    idle(1);
    check1("token_consumed", {31'd0, rx_has_data}, 32'd0);

    // DATA_C with good then bad checksum.
    push(EV_PKT, 3'b010, 4'h1, 1'b0, 32'h44332211);
    drive(8'h42, 1'b0); drive(8'h11, 1'b0); drive(8'h22, 1'b0);
    drive(8'h33, 1'b0); drive(8'h44, 1'b0); drive(8'h06, 1'b0);
    idle(2); consume(); idle(1);
    push(EV_PKT, 3'b010, 4'h1, 1'b1, 32'h44332211);
    drive(8'h42, 1'b0); drive(8'h11, 1'b0); drive(8'h22, 1'b0);
    drive(8'h33, 1'b0); drive(8'h44, 1'b0); drive(8'h07, 1'b0);
    idle(2); consume(); idle(1);

    // DATA_3 with a corrupted byte in copy2, corrected by the vote.
    push(EV_PKT, 3'b001, 4'h3, 1'b0, 32'hDDCCBBAA);
    drive(8'h27, 1'b0);
    drive(8'hAA, 1'b0); drive(8'hBB, 1'b0); drive(8'hCC, 1'b0); drive(8'hDD, 1'b0);
    drive(8'hAB, 1'b0); drive(8'hBB, 1'b0); drive(8'hCC, 1'b0); drive(8'hDD, 1'b0);
    drive(8'hAA, 1'b0); drive(8'hBB, 1'b0); drive(8'hCC, 1'b0); drive(8'hDD, 1'b0);
    idle(2); consume(); idle(1);

    // Bad parity header, then a byte after only 63 quiet cycles (ignored),
    // then a byte after exactly 64 quiet cycles (accepted).
    push(EV_PKT, 3'b111, 4'h1, 1'b1, 32'h0);
    drive(8'hE3, 1'b0);
    idle(2); consume(); idle(60);
    drive(8'hE2, 1'b0);
    idle(64);
    push(EV_PKT, 3'b111, 4'h1, 1'b0, 32'h0);
    drive(8'hE2, 1'b0);
    idle(2); consume(); idle(1);

    // Overrun: held packet kept; then new header with same-cycle rc_ready.
    push(EV_PKT, 3'b111, 4'h1, 1'b0, 32'h0);
    drive(8'hE2, 1'b0);
    idle(2);
    push(EV_OVR, 3'b000, 4'h0, 1'b0, 32'h0);
    drive(8'hE2, 1'b0);
    idle(64);
    push(EV_PKT, 3'b111, 4'h2, 1'b0, 32'h0);
    drive(8'hE4, 1'b1);
    idle(2);
    check1("backtoback_has", {31'd0, rx_has_data}, 32'd1);
    consume(); idle(1);

    // Mid-packet timeout: pulse, nothing presented.
    push(EV_TMO, 3'b000, 4'h0, 1'b0, 32'h0);
    drive(8'h42, 1'b0); drive(8'h11, 1'b0);
    idle(66);
    check1("timeout_no_data", {31'd0, rx_has_data}, 32'd0);

    // Reset mid-DATA_3 clears everything and returns to IDLE.
    drive(8'h27, 1'b0); drive(8'hAA, 1'b0); drive(8'hBB, 1'b0);
    Rst_n = 1'b0;
    @(posedge Clk_R); #1;
    check_all_zero("midreset");
    Rst_n = 1'b1;
    push(EV_PKT, 3'b111, 4'h1, 1'b0, 32'h0);
    drive(8'hE2, 1'b0);
    idle(2); consume(); idle(2);

    check1("scoreboard_empty", q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
